// File: rtl/int_reg_pkg.sv
// Shared types and constants for the integer register file writeback path.
// Used by the scheduler top, its arbiter and the bundle interface.
package int_reg_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Architectural register 0 is hardwired; writes to it are dropped.
  localparam reg_addr_t REG_ZERO = '0;

  // One writeback request as presented by an execute unit.
  typedef struct packed {
    logic            valid;
    reg_addr_t       rd;
    logic [XLEN-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/int_reg_wb_sched_if.sv
// Issue, writeback-request and register-file-port signals of the
// writeback scheduler. slave = scheduler side, master = surrounding pipeline.
interface int_reg_wb_sched_if;
  import int_reg_pkg::*;

  logic            issue_valid;
  reg_addr_t       issue_rd;
  reg_addr_t       issue_rs1;
  reg_addr_t       issue_rs2;
  logic            issue_ready;

  logic            alu_valid;
  reg_addr_t       alu_rd;
  logic [XLEN-1:0] alu_wdata;
  logic            alu_ready;

  logic            lsu_valid;
  reg_addr_t       lsu_rd;
  logic [XLEN-1:0] lsu_wdata;
  logic            lsu_ready;

  logic            rd_wen;
  reg_addr_t       rd_addr;
  logic [XLEN-1:0] rd_wdata;
  logic            wb_err;

  modport slave (
    input  issue_valid, issue_rd, issue_rs1, issue_rs2,
    output issue_ready,
    input  alu_valid, alu_rd, alu_wdata,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_wdata,
    output lsu_ready,
    output rd_wen, rd_addr, rd_wdata, wb_err
  );

  modport master (
    output issue_valid, issue_rd, issue_rs1, issue_rs2,
    input  issue_ready,
    output alu_valid, alu_rd, alu_wdata,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_wdata,
    input  lsu_ready,
    input  rd_wen, rd_addr, rd_wdata, wb_err
  );

endinterface

// File: rtl/int_reg_wb_arb.sv
// Two-way writeback arbiter (ALU vs LSU) for the single register-file
// write port. Macro WB_RR_EN selects round-robin on contention; without it
// the LSU has fixed priority and no state is kept.
module int_reg_wb_arb (
`ifdef WB_RR_EN
  input  logic i_clk,
  input  logic i_rst_n,
`endif
  input  logic i_alu_valid,
  input  logic i_lsu_valid,
  output logic o_alu_gnt,
  output logic o_lsu_gnt
);

`ifdef WB_RR_EN
  // High when the ALU wins the next contended cycle.
  logic r_ptr_alu;
  logic w_contend;

  assign w_contend = i_alu_valid & i_lsu_valid;

  // Grant: a lone requester always wins; on contention the pointer decides.
  always_comb begin
    o_alu_gnt = i_alu_valid & (~i_lsu_valid | r_ptr_alu);
    o_lsu_gnt = i_lsu_valid & (~i_alu_valid | ~r_ptr_alu);
  end

  // Pointer flips only on contended cycles so the loser wins next time.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr_alu <= 1'b1;
    end else if (w_contend) begin
      r_ptr_alu <= ~r_ptr_alu;
    end
  end
`else
  // Grant: fixed priority, LSU ahead of ALU.
  always_comb begin
    o_lsu_gnt = i_lsu_valid;
    o_alu_gnt = i_alu_valid & ~i_lsu_valid;
  end
`endif

endmodule

// File: rtl/int_reg_wb_sched.sv
// Integer register file writeback scheduler and scoreboard.
// Tracks in-flight destinations (busy bits), blocks issue on RAW/WAW,
// arbitrates ALU/LSU onto the single write port and registers the port.
// Optional macro WB_RR_EN: round-robin arbitration instead of LSU priority.
module int_reg_wb_sched
  import int_reg_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  int_reg_wb_sched_if.slave  wb
);

  // Scoreboard; register 0 has no entry and is never busy.
  logic [NUM_REGS-1:1] r_busy;
  logic [NUM_REGS-1:1] w_busy_nxt;
  logic [NUM_REGS-1:0] w_busy_full;

  logic                r_rd_wen;
  reg_addr_t           r_rd_addr;
  logic [XLEN-1:0]     r_rd_wdata;
  logic                r_wb_err;

  wb_req_t             w_alu_req;
  wb_req_t             w_lsu_req;
  wb_req_t             w_gnt_req;
  logic                w_alu_gnt;
  logic                w_lsu_gnt;
  logic                w_gnt;
  logic                w_gnt_live;
  logic                w_gnt_stray;
  logic                w_issue_ready;
  logic                w_issue_fire;

  assign w_busy_full = {r_busy, 1'b0};

  // Hazard check: any source or the destination still in flight stalls issue.
  assign w_issue_ready = ~(w_busy_full[wb.issue_rs1] |
                           w_busy_full[wb.issue_rs2] |
                           w_busy_full[wb.issue_rd]);
  assign w_issue_fire  = wb.issue_valid & w_issue_ready;
  assign wb.issue_ready = w_issue_ready;

  assign w_alu_req = '{valid: wb.alu_valid, rd: wb.alu_rd, wdata: wb.alu_wdata};
  assign w_lsu_req = '{valid: wb.lsu_valid, rd: wb.lsu_rd, wdata: wb.lsu_wdata};

  int_reg_wb_arb u_arb (
`ifdef WB_RR_EN
    .i_clk       (clk),
    .i_rst_n     (rst_n),
`endif
    .i_alu_valid (w_alu_req.valid),
    .i_lsu_valid (w_lsu_req.valid),
    .o_alu_gnt   (w_alu_gnt),
    .o_lsu_gnt   (w_lsu_gnt)
  );

  assign wb.alu_ready = w_alu_gnt;
  assign wb.lsu_ready = w_lsu_gnt;

  assign w_gnt_req   = w_lsu_gnt ? w_lsu_req : w_alu_req;
  assign w_gnt       = w_gnt_req.valid & (w_alu_gnt | w_lsu_gnt);
  // Writes to x0 are accepted but never reach the register file.
  assign w_gnt_live  = w_gnt & (w_gnt_req.rd != REG_ZERO);
  // A live writeback whose destination was never marked in flight.
  assign w_gnt_stray = w_gnt_live & ~w_busy_full[w_gnt_req.rd];

  // Next scoreboard: writeback clears, issue sets; set is applied last so it wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_gnt_live) begin
      w_busy_nxt[w_gnt_req.rd] = 1'b0;
    end
    if (w_issue_fire && (wb.issue_rd != REG_ZERO)) begin
      w_busy_nxt[wb.issue_rd] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Write-port register: enable pulses for one cycle, address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_wen   <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_wdata <= '0;
    end else begin
      r_rd_wen <= w_gnt_live;
      if (w_gnt) begin
        r_rd_addr  <= w_gnt_req.rd;
        r_rd_wdata <= w_gnt_req.wdata;
      end
    end
  end

  // Sticky error flag for writebacks to registers that were not in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_err <= 1'b0;
    end else if (w_gnt_stray) begin
      r_wb_err <= 1'b1;
    end
  end

  assign wb.rd_wen   = r_rd_wen;
  assign wb.rd_addr  = r_rd_addr;
  assign wb.rd_wdata = r_rd_wdata;
  assign wb.wb_err   = r_wb_err;

endmodule
